prog_sequencer: RTL and testbench

//  Parametrised instruction sequencer replacing the fixed 8-bit PC/jump-LUT pair in the core top level.

---
 rtl/prog_sequencer_pkg.sv | 12 +
 rtl/prog_sequencer_if.sv | 37 +++
 rtl/prog_sequencer_ret_stack.sv | 45 ++++
 rtl/prog_sequencer.sv | 140 ++++++++++++++
 tb/tb_prog_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared types and default sizing for the program sequencer.
package prog_seq_pkg;
  localparam int DEF_PC_W        = 8;
  localparam int DEF_JPTR_W      = 5;
  localparam int DEF_STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/prog_sequencer_if.sv
// Control-strobe / fetch-address bundle between decode logic and the sequencer.
interface prog_sequencer_if
  import prog_seq_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int JPTR_W = DEF_JPTR_W
);
  logic              start;
  logic              halt;
  logic              stall;
  logic              jen;
  logic              zero;
  logic              call;
  logic              ret;
  logic [JPTR_W-1:0] jptr;
  logic              jtab_we;
  logic [JPTR_W-1:0] jtab_waddr;
  logic [PC_W-1:0]   jtab_wdata;
  logic [PC_W-1:0]   pc;
  logic              running;
  logic              done;
  logic              stack_err;

  // Decode / host side: drives strobes, observes fetch address and status.
  modport master (
    output start, halt, stall, jen, zero, call, ret, jptr,
           jtab_we, jtab_waddr, jtab_wdata,
    input  pc, running, done, stack_err
  );

  // Sequencer side.
  modport slave (
    input  start, halt, stall, jen, zero, call, ret, jptr,
           jtab_we, jtab_waddr, jtab_wdata,
    output pc, running, done, stack_err
  );
endinterface

// File: rtl/prog_sequencer_ret_stack.sv
// Return-address LIFO. Caller guarantees push and pop are never both set.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  r_sp;
  logic [W-1:0]     r_mem [DEPTH];
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_push_idx;

  // When empty the top index aliases a stale slot; callers never consume it then.
  assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_push_idx = IDX_W'(r_sp);
  assign o_full     = (r_sp == SP_W'(DEPTH));
  assign o_empty    = (r_sp == SP_W'(0));
  assign o_top      = r_mem[w_top_idx];

  // Stack pointer and storage update; clear discards all entries on program launch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp <= SP_W'(0);
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= W'(0);
    end else if (i_clr) begin
      r_sp <= SP_W'(0);
    end else if (i_push && !o_full) begin
      r_mem[w_push_idx] <= i_wdata;
      r_sp              <= r_sp + SP_W'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end
endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: launch/done handshake, PC generation, writable jump table
// and a hardware call/return stack.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int JPTR_W      = DEF_JPTR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input logic             i_clk,
  input logic             i_rst,
  prog_sequencer_if.slave bus
);
  localparam int JT_N = 2 ** JPTR_W;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic            r_running;
  logic            r_done;
  logic [PC_W-1:0] r_jtab [JT_N];
  logic [PC_W-1:0] w_jt_target;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_push;
  logic            w_pop;
  logic            w_clr;
  logic [PC_W-1:0] w_stk_top;
  logic            w_stk_full;
  logic            w_stk_empty;

  // Lookup sees the pre-write table contents, so a same-cycle write is not forwarded.
  assign w_jt_target = r_jtab[bus.jptr];
  assign w_pc_inc    = r_pc + PC_W'(1);

  ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_ret_stack (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_pc_inc),
    .o_top   (w_stk_top),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  // Next-state and next-PC selection; strobes are only honoured in RUN, in fixed priority.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = PC_W'(0);
          w_err_nxt   = 1'b0;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (bus.halt) begin
          w_state_nxt = DONE;
        end else if (bus.stall) begin
          w_pc_nxt = r_pc;
        end else if (bus.ret) begin
          if (!w_stk_empty) begin
            w_pop    = 1'b1;
            w_pc_nxt = w_stk_top;
          end else begin
            w_err_nxt = 1'b1;
            w_pc_nxt  = w_pc_inc;
          end
        end else if (bus.call) begin
          if (!w_stk_full) begin
            w_push   = 1'b1;
            w_pc_nxt = w_jt_target;
          end else begin
            w_err_nxt = 1'b1;
            w_pc_nxt  = w_pc_inc;
          end
        end else if (bus.jen && bus.zero) begin
          w_pc_nxt = w_jt_target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      DONE: begin
        if (!bus.start) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = PC_W'(0);
      end
    endcase
  end

  // Sequencer state, PC and status registers; status outputs come straight from flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_pc      <= PC_W'(0);
      r_err     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_err     <= w_err_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  // Jump table is writable in every state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < JT_N; i++) r_jtab[i] <= PC_W'(0);
    end else if (bus.jtab_we) begin
      r_jtab[bus.jtab_waddr] <= bus.jtab_wdata;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.running   = r_running;
  assign bus.done      = r_done;
  assign bus.stack_err = r_err;
endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus randomized
// strobes, all checked against a queue-based behavioural model.
module tb_prog_sequencer;
  localparam int PC_W   = 8;
  localparam int JPTR_W = 5;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_sequencer_if #(.PC_W(PC_W), .JPTR_W(JPTR_W)) bus ();

  prog_sequencer #(.PC_W(PC_W), .JPTR_W(JPTR_W), .STACK_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0=idle 1=run 2=done
  int         m_mode;
  logic [7:0] m_pc;
  bit         m_err;
  logic [7:0] m_stack [$];
  logic [7:0] m_jtab [32];

  logic [10:0] obs;
  logic [10:0] exp_v;

  task automatic model_reset();
    m_mode = 0; m_pc = 8'h00; m_err = 1'b0;
    m_stack.delete();
    for (int i = 0; i < 32; i++) m_jtab[i] = 8'h00;
  endtask

  task automatic model_edge();
    logic [7:0] tgt;
    tgt = m_jtab[bus.jptr];
    if (m_mode == 0) begin
      if (bus.start) begin m_mode = 1; m_pc = 8'h00; m_err = 1'b0; m_stack.delete(); end
    end else if (m_mode == 1) begin
      if (bus.halt) m_mode = 2;
      else if (bus.stall) m_pc = m_pc;
      else if (bus.ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_err = 1'b1; m_pc = m_pc + 8'd1; end
      end else if (bus.call) begin
        if (m_stack.size() < DEPTH) begin m_stack.push_back(m_pc + 8'd1); m_pc = tgt; end
        else begin m_err = 1'b1; m_pc = m_pc + 8'd1; end
      end else if (bus.jen && bus.zero) m_pc = tgt;
      else m_pc = m_pc + 8'd1;
    end else begin
      if (!bus.start) m_mode = 0;
    end
    if (bus.jtab_we) m_jtab[bus.jtab_waddr] = bus.jtab_wdata;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.halt = 1'b0; bus.stall = 1'b0; bus.jen = 1'b0;
    bus.zero = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.jptr = 5'd0;
    bus.jtab_we = 1'b0; bus.jtab_waddr = 5'd0; bus.jtab_wdata = 8'h00;
  endtask

  // One clock: model follows the edge, outputs are then observed at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    obs   = {bus.pc, bus.running, bus.done, bus.stack_err};
    exp_v = {m_pc, (m_mode == 1), (m_mode == 2), m_err};
    clear_inputs();
  endtask

  task automatic jt_write(input logic [4:0] a, input logic [7:0] d);
    bus.jtab_we = 1'b1; bus.jtab_waddr = a; bus.jtab_wdata = d;
    tick();
  endtask

  task automatic jump(input logic [4:0] a);
    bus.jen = 1'b1; bus.zero = 1'b1; bus.jptr = a;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs(); model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = {bus.pc, bus.running, bus.done, bus.stack_err};
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs, 11'd0); end
  endtask

  task automatic test_count();
    jt_write(5'd3, 8'h40); jt_write(5'd4, 8'h05); jt_write(5'd1, 8'h20);
    jt_write(5'd5, 8'h10); jt_write(5'd6, 8'h30); jt_write(5'd7, 8'hFE);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL idle_hold got=%h want=%h", obs, exp_v); end
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      total++;
      if (bus.pc !== 8'(i) || bus.running !== 1'b1 || bus.done !== 1'b0 || obs !== exp_v) begin
        bad++; $display("FAIL count_%0d got pc=%h run=%b done=%b want pc=%h", i, bus.pc, bus.running, bus.done, 8'(i));
      end
    end
  endtask

  task automatic test_branch();
    tick();
    total++;
    if (bus.pc !== 8'h05) begin bad++; $display("FAIL pre_branch got=%h want=05", bus.pc); end
    // Same-cycle rewrite of the looked-up entry must not be seen yet.
    bus.jtab_we = 1'b1; bus.jtab_waddr = 5'd3; bus.jtab_wdata = 8'h50;
    jump(5'd3);
    total++;
    if (bus.pc !== 8'h40 || obs !== exp_v) begin bad++; $display("FAIL branch_taken got=%h want=40", bus.pc); end
    jump(5'd4);
    bus.jen = 1'b1; bus.zero = 1'b0; bus.jptr = 5'd3;
    tick();
    total++;
    if (bus.pc !== 8'h06 || obs !== exp_v) begin bad++; $display("FAIL branch_not_taken got=%h want=06", bus.pc); end
  endtask

  task automatic test_call_ret();
    jump(5'd5);
    bus.call = 1'b1; bus.jptr = 5'd1;
    tick();
    total++;
    if (bus.pc !== 8'h20 || obs !== exp_v) begin bad++; $display("FAIL call_target got=%h want=20", bus.pc); end
    tick(); tick();
    bus.ret = 1'b1;
    tick();
    total++;
    if (bus.pc !== 8'h11 || obs !== exp_v) begin bad++; $display("FAIL ret_addr got=%h want=11", bus.pc); end
  endtask

  task automatic test_overflow();
    logic [7:0] prev;
    for (int i = 0; i < 5; i++) begin
      prev = bus.pc;
      bus.call = 1'b1; bus.jptr = 5'd1;
      tick();
      total++;
      if (i < 4 && (bus.pc !== 8'h20 || bus.stack_err !== 1'b0)) begin
        bad++; $display("FAIL call_nest_%0d got pc=%h err=%b want pc=20 err=0", i, bus.pc, bus.stack_err);
      end else if (i == 4 && (bus.pc !== prev + 8'd1 || bus.stack_err !== 1'b1)) begin
        bad++; $display("FAIL overflow got pc=%h err=%b want pc=%h err=1", bus.pc, bus.stack_err, prev + 8'd1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      bus.ret = 1'b1;
      tick();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL unwind_%0d got=%h want=%h", i, obs, exp_v); end
    end
    prev = bus.pc;
    bus.ret = 1'b1;
    tick();
    total++;
    if (bus.pc !== prev + 8'd1 || bus.stack_err !== 1'b1) begin
      bad++; $display("FAIL underflow got pc=%h err=%b want pc=%h err=1", bus.pc, bus.stack_err, prev + 8'd1);
    end
  endtask

  task automatic test_halt();
    jump(5'd6);
    bus.halt = 1'b1;
    tick();
    total++;
    if (bus.pc !== 8'h30 || bus.done !== 1'b1 || bus.running !== 1'b0 || obs !== exp_v) begin
      bad++; $display("FAIL halt got pc=%h done=%b want pc=30 done=1", bus.pc, bus.done);
    end
    for (int i = 0; i < 3; i++) begin bus.start = 1'b1; tick(); end
    total++;
    if (bus.done !== 1'b1 || bus.pc !== 8'h30) begin bad++; $display("FAIL done_hold got done=%b pc=%h want 1/30", bus.done, bus.pc); end
    tick();
    total++;
    if (bus.done !== 1'b0 || bus.running !== 1'b0) begin bad++; $display("FAIL rearm got done=%b run=%b want 0/0", bus.done, bus.running); end
    bus.start = 1'b1;
    tick();
    total++;
    if (bus.pc !== 8'h00 || bus.running !== 1'b1 || bus.stack_err !== 1'b0 || obs !== exp_v) begin
      bad++; $display("FAIL relaunch got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_wrap_stall();
    jump(5'd7);
    tick();
    total++;
    if (bus.pc !== 8'hFF) begin bad++; $display("FAIL pre_wrap got=%h want=ff", bus.pc); end
    tick();
    total++;
    if (bus.pc !== 8'h00 || obs !== exp_v) begin bad++; $display("FAIL wrap got=%h want=00", bus.pc); end
    bus.stall = 1'b1; bus.call = 1'b1; bus.jptr = 5'd1;
    tick();
    total++;
    if (bus.pc !== 8'h00) begin bad++; $display("FAIL stall_call got=%h want=00", bus.pc); end
    bus.ret = 1'b1;
    tick();
    total++;
    if (bus.pc !== 8'h01 || bus.stack_err !== 1'b1) begin
      bad++; $display("FAIL stall_no_push got pc=%h err=%b want 01/1", bus.pc, bus.stack_err);
    end
    rst = 1'b1; model_reset();
    #1;
    obs = {bus.pc, bus.running, bus.done, bus.stack_err};
    total++;
    if (obs !== 11'd0) begin bad++; $display("FAIL reset_mid_run got=%h want=%h", obs, 11'd0); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      bus.start      = ($urandom_range(0, 9) < 3);
      bus.halt       = ($urandom_range(0, 39) == 0);
      bus.stall      = ($urandom_range(0, 7) == 0);
      bus.jen        = 1'($urandom);
      bus.zero       = 1'($urandom);
      bus.call       = ($urandom_range(0, 5) == 0);
      bus.ret        = ($urandom_range(0, 5) == 0);
      bus.jptr       = 5'($urandom);
      bus.jtab_we    = ($urandom_range(0, 3) == 0);
      bus.jtab_waddr = 5'($urandom);
      bus.jtab_wdata = 8'($urandom);
      tick();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL random_c%0d got=%h want=%h", c, obs, exp_v); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_count();
    test_branch();
    test_call_ret();
    test_overflow();
    test_halt();
    test_wrap_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
